// File: rtl/rptr_empty_if.sv
// Read-port bundle for the FIFO read-pointer/empty controller: consumer
// request, synchronized write pointer, storage address and status flags.
interface rptr_empty_if #(
    parameter int ADDRSIZE = 8
);
    logic                rinc;
    logic [ADDRSIZE:0]   rq2_wptr;
    logic                err_clr;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                rempty_almost;
    logic [ADDRSIZE:0]   rlevel;
    logic                rd_fire;
    logic                fifo_error_r;
    logic                underflow_sticky;

    modport master (
        output rinc, rq2_wptr, err_clr,
        input  raddr, rptr, rempty, rempty_almost, rlevel,
               rd_fire, fifo_error_r, underflow_sticky
    );

    modport slave (
        input  rinc, rq2_wptr, err_clr,
        output raddr, rptr, rempty, rempty_almost, rlevel,
               rd_fire, fifo_error_r, underflow_sticky
    );
endinterface

// File: rtl/rptr_empty_ctrl.sv
// Read-domain pointer and empty/almost-empty/level/underflow controller for an
// asynchronous FIFO; rptr is the Gray pointer handed to the write-domain sync.
module rptr_empty_ctrl #(
    parameter int ADDRSIZE      = 8,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic         rclk,
    input  logic         rrst,
    rptr_empty_if.slave  rif
);
    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] rbin_q,   rbin_d;
    logic [PW-1:0] rgray_q,  rgray_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          rempty_q, rempty_d;
    logic          ralmost_q, ralmost_d;
    logic          sticky_q, sticky_d;
    logic [PW-1:0] rwbin;
    logic          rd_fire;
    logic          fifo_err;

    always_comb begin
        rd_fire  = rif.rinc & ~rempty_q;
        fifo_err = rif.rinc & rempty_q & ~rrst;

        rbin_d  = rbin_q + {{(PW-1){1'b0}}, rd_fire};
        rgray_d = (rbin_d >> 1) ^ rbin_d;

        // Gray-to-binary: each bit is the XOR of itself and all bits above it
        rwbin = '0;
        for (int i = 0; i < PW; i++) begin
            rwbin[i] = ^(rif.rq2_wptr >> i);
        end

        rlevel_d  = rwbin - rbin_d;
        rempty_d  = (rgray_d == rif.rq2_wptr);
        ralmost_d = (rlevel_d <= PW'(AEMPTY_THRESH));

        // A new underflow takes priority over a clear in the same cycle
        sticky_d = sticky_q;
        if (fifo_err) begin
            sticky_d = 1'b1;
        end else if (rif.err_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q    <= '0;
            rgray_q   <= '0;
            rlevel_q  <= '0;
            rempty_q  <= 1'b1;
            ralmost_q <= 1'b1;
            sticky_q  <= 1'b0;
        end else begin
            rbin_q    <= rbin_d;
            rgray_q   <= rgray_d;
            rlevel_q  <= rlevel_d;
            rempty_q  <= rempty_d;
            ralmost_q <= ralmost_d;
            sticky_q  <= sticky_d;
        end
    end

    assign rif.raddr            = rbin_q[ADDRSIZE-1:0];
    assign rif.rptr             = rgray_q;
    assign rif.rempty           = rempty_q;
    assign rif.rempty_almost    = ralmost_q;
    assign rif.rlevel           = rlevel_q;
    assign rif.rd_fire          = rd_fire;
    assign rif.fifo_error_r     = fifo_err;
    assign rif.underflow_sticky = sticky_q;
endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Scoreboard bench: a read/write-count model predicts each cycle's outputs,
// a separate monitor pops and compares them against the DUT.
module tb_rptr_empty_ctrl;
    localparam int A     = 8;
    localparam int PW    = A + 1;
    localparam int MOD   = 1 << PW;
    localparam int DEPTH = 1 << A;
    localparam int THR   = 2;

    logic clk;
    logic rrst;

    rptr_empty_if #(.ADDRSIZE(A)) rif ();

    rptr_empty_ctrl #(.ADDRSIZE(A), .AEMPTY_THRESH(THR)) dut (
        .rclk (clk),
        .rrst (rrst),
        .rif  (rif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit         regs_valid;
        logic       fire;
        logic       err;
        logic [A-1:0]  raddr;
        logic [PW-1:0] rptr;
        logic       empty;
        logic       almost;
        logic [PW-1:0] level;
        logic       sticky;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: total entries written and read, plus registered flags
    int rd_cnt = 0;
    int wr_cnt = 0;
    bit m_empty, m_almost, m_sticky, m_known;
    int m_level;

    function automatic logic [PW-1:0] to_gray(int b);
        int v;
        v = b % MOD;
        return PW'(v ^ (v >> 1));
    endfunction

    function automatic int occupancy(int w, int r);
        return (((w - r) % MOD) + MOD) % MOD;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(bit rinc, int wadv, bit clr, bit rst);
        exp_t e;
        bit   fire;
        @(posedge clk);
        #1;
        wr_cnt += wadv;
        rif.rinc     = rinc;
        rif.err_clr  = clr;
        rif.rq2_wptr = to_gray(wr_cnt);
        rrst         = rst;

        fire         = rinc && m_known && !m_empty;
        e.regs_valid = m_known;
        e.fire       = fire;
        e.err        = rinc && m_empty && !rst;
        e.raddr      = A'(rd_cnt % DEPTH);
        e.rptr       = to_gray(rd_cnt);
        e.empty      = m_empty;
        e.almost     = m_almost;
        e.level      = PW'(m_level);
        e.sticky     = m_sticky;
        exp_q.push_back(e);

        if (rst) begin
            rd_cnt   = 0;
            m_empty  = 1'b1;
            m_almost = 1'b1;
            m_level  = 0;
            m_sticky = 1'b0;
            m_known  = 1'b1;
        end else begin
            if (e.err) m_sticky = 1'b1;
            else if (clr) m_sticky = 1'b0;
            if (fire) rd_cnt++;
            m_level  = occupancy(wr_cnt, rd_cnt);
            m_empty  = (m_level == 0);
            m_almost = (m_level <= THR);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rd_fire",      32'(rif.rd_fire),      32'(e.fire));
                chk("fifo_error_r", 32'(rif.fifo_error_r), 32'(e.err));
                if (e.regs_valid) begin
                    chk("raddr",            32'(rif.raddr),            32'(e.raddr));
                    chk("rptr",             32'(rif.rptr),             32'(e.rptr));
                    chk("rempty",           32'(rif.rempty),           32'(e.empty));
                    chk("rempty_almost",    32'(rif.rempty_almost),    32'(e.almost));
                    chk("rlevel",           32'(rif.rlevel),           32'(e.level));
                    chk("underflow_sticky", 32'(rif.underflow_sticky), 32'(e.sticky));
                end
            end
        end
    end

    initial begin : driver
        int lvl;
        int wadv;
        rif.rinc     = 1'b0;
        rif.err_clr  = 1'b0;
        rif.rq2_wptr = '0;
        rrst         = 1'b1;
        m_known      = 1'b0;
        m_empty      = 1'b1;
        m_almost     = 1'b1;
        m_sticky     = 1'b0;
        m_level      = 0;

        // Reset for two edges, then observe the idle reset state
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Fill to three, drain three, observe empty
        step(0, 3, 0, 0);
        repeat (3) step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // Underflow, sticky set; clear racing a new underflow; clear alone
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Simultaneous read and write at level 1
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);

        // Write pointer one ahead while reading through more than a full pointer wrap
        repeat (MOD + 8) step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // Reset coinciding with a read at level 5
        step(0, 5, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        step(0, 0, 0, 0);

        // Fill to the full depth, then drain completely
        lvl = occupancy(wr_cnt, rd_cnt);
        step(0, DEPTH - lvl, 0, 0);
        repeat (DEPTH + 2) step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // Randomized traffic keeping the level legal
        repeat (1500) begin
            lvl  = occupancy(wr_cnt, rd_cnt);
            wadv = $urandom_range(0, 2);
            if (lvl + wadv > DEPTH) wadv = DEPTH - lvl;
            step(1'($urandom_range(0, 1)), wadv, ($urandom_range(0, 15) == 0), 1'b0);
        end
        step(0, 0, 0, 0);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
